collision_arbiter: RTL and testbench

COLLISION_ARBITER -- requirements
Module: collision_arbiter

---
 rtl/collision_arbiter_if.sv | 30 +++
 rtl/collision_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_collision_arbiter.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/collision_arbiter_if.sv
// Collision event stream between the arbiter and its consumer.
// Valid/ready handshake; the head fields are meaningful while evt_valid is high.
interface collision_arbiter_if #(
    parameter int unsigned IDXW = 1
) ();
    logic            evt_valid;
    logic            evt_ready;
    logic [IDXW-1:0] evt_ball;
    logic [3:0]      evt_side;
    logic            evt_brick;
    logic [2:0]      evt_batZone;

    modport master (
        output evt_valid,
        output evt_ball,
        output evt_side,
        output evt_brick,
        output evt_batZone,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_ball,
        input  evt_side,
        input  evt_brick,
        input  evt_batZone,
        output evt_ready
    );
endinterface

// File: rtl/collision_arbiter.sv
// Ball collision arbiter: picks one armed ball per cycle, classifies the hit side and bat zone,
// and queues the event in a small FIFO; also tracks per-frame hit counts and bonus pickups.
module collision_arbiter #(
    parameter int unsigned NUM_BALLS = 2,
    parameter int unsigned BALL_W    = 14,
    parameter int unsigned EDGE      = 3,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic                     startOfFrame,
    input  logic [NUM_BALLS-1:0]     ballReq,
    input  logic [11*NUM_BALLS-1:0]  ballOffsetX,
    input  logic [11*NUM_BALLS-1:0]  ballOffsetY,
    input  logic                     brikReq,
    input  logic                     batReq,
    input  logic                     bonusDrawReq,
    input  logic [10:0]              batOffSetX,
    input  logic [2:0]               legnth,
    collision_arbiter_if.master      evt,
    output logic                     overflow,
    output logic                     bonusCollision,
    output logic [7:0]               lastFrameHits
);

    localparam int unsigned IDXW = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;
    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned EW   = IDXW + 8;

    localparam logic [10:0] HalfW  = 11'(BALL_W / 2);
    localparam logic [10:0] EdgeLo = 11'(EDGE);
    localparam logic [10:0] EdgeHi = 11'(BALL_W - 1 - EDGE);
    localparam logic [10:0] ZoneT [6] = '{11'd4, 11'd9, 11'd13, 11'd14, 11'd18, 11'd23};

    // ---------------- arbitration ----------------
    logic [NUM_BALLS-1:0] armed_q, armed_d, armed_eff, cand, win_oh;
    logic [IDXW-1:0]      win_idx;
    logic                 win_any;

    // startOfFrame re-arms in the same cycle, so a simultaneous candidate counts as armed.
    always_comb begin
        armed_eff = armed_q | {NUM_BALLS{startOfFrame}};
        cand      = ballReq & armed_eff & {NUM_BALLS{brikReq | batReq}};
        win_idx   = '0;
        win_oh    = '0;
        for (int i = NUM_BALLS - 1; i >= 0; i--) begin
            if (cand[i]) begin
                win_idx   = IDXW'(i);
                win_oh    = '0;
                win_oh[i] = 1'b1;
            end
        end
        win_any = |cand;
        armed_d = armed_eff & ~win_oh;
    end

    // ---------------- classification ----------------
    logic [10:0] win_x, win_y;
    logic [3:0]  side_c;
    logic [2:0]  zone_c;
    logic [1:0]  shamt;

    always_comb begin
        win_x = ballOffsetX[win_idx*11 +: 11];
        win_y = ballOffsetY[win_idx*11 +: 11];
        if (win_y > EdgeHi) begin
            side_c = 4'b0010;
        end else if (win_y < EdgeLo) begin
            side_c = 4'b0001;
        end else if (win_x < HalfW) begin
            side_c = 4'b1000;
        end else begin
            side_c = 4'b0100;
        end
        shamt  = legnth[2:1];
        zone_c = 3'd0;
        if (side_c == 4'b0010 && batReq) begin
            zone_c = 3'd7;
            // Scan high to low so the lowest matching threshold wins.
            for (int k = 5; k >= 0; k--) begin
                if (batOffSetX < (ZoneT[k] << shamt)) zone_c = 3'(k + 1);
            end
        end
    end

    // ---------------- classification stage ----------------
    logic            stage_valid_q;
    logic [IDXW-1:0] stage_ball_q;
    logic [3:0]      stage_side_q;
    logic            stage_brick_q;
    logic [2:0]      stage_zone_q;

    // ---------------- event FIFO ----------------
    logic [EW-1:0] mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [PW:0]   count_q, count_d;
    logic          full, fifo_valid, push, pop, push_ok;
    logic [EW-1:0] head;

    always_comb begin
        fifo_valid = (count_q != '0);
        full       = (count_q == (PW + 1)'(DEPTH));
        push       = stage_valid_q;
        pop        = fifo_valid && evt.evt_ready;
        push_ok    = push && (!full || pop);
        count_d    = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop) begin
            count_d = count_q - 1'b1;
        end
        head = mem_q[rd_ptr_q];
    end

    assign evt.evt_valid   = fifo_valid;
    assign evt.evt_ball    = fifo_valid ? head[EW-1:8] : '0;
    assign evt.evt_side    = fifo_valid ? head[7:4]    : '0;
    assign evt.evt_brick   = fifo_valid ? head[3]      : 1'b0;
    assign evt.evt_batZone = fifo_valid ? head[2:0]    : '0;

    // ---------------- frame counter, bonus, overflow ----------------
    logic [7:0] hits_q, hits_d, last_q, last_d;
    logic       bonus_armed_q, bonus_armed_d, bonus_eff, bonus_fire, bonus_q;
    logic       ovf_q, ovf_d;

    always_comb begin
        hits_d = hits_q;
        last_d = last_q;
        if (startOfFrame) begin
            last_d = hits_q;
            hits_d = push_ok ? 8'd1 : 8'd0;
        end else if (push_ok && hits_q != 8'hFF) begin
            hits_d = hits_q + 8'd1;
        end
        bonus_eff     = bonus_armed_q | startOfFrame;
        bonus_fire    = batReq && bonusDrawReq && bonus_eff;
        bonus_armed_d = bonus_eff && !bonus_fire;
        ovf_d         = ovf_q | (push && !push_ok);
    end

    assign overflow       = ovf_q;
    assign bonusCollision = bonus_q;
    assign lastFrameHits  = last_q;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            armed_q       <= '1;
            stage_valid_q <= 1'b0;
            stage_ball_q  <= '0;
            stage_side_q  <= '0;
            stage_brick_q <= 1'b0;
            stage_zone_q  <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            hits_q        <= '0;
            last_q        <= '0;
            bonus_armed_q <= 1'b1;
            bonus_q       <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            armed_q       <= armed_d;
            stage_valid_q <= win_any;
            if (win_any) begin
                stage_ball_q  <= win_idx;
                stage_side_q  <= side_c;
                stage_brick_q <= brikReq;
                stage_zone_q  <= zone_c;
            end
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q       <= count_d;
            hits_q        <= hits_d;
            last_q        <= last_d;
            bonus_armed_q <= bonus_armed_d;
            bonus_q       <= bonus_fire;
            ovf_q         <= ovf_d;
        end
    end

    // Storage needs no reset: the occupancy counter alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= {stage_ball_q, stage_side_q, stage_brick_q, stage_zone_q};
    end

endmodule

// File: tb/tb_collision_arbiter.sv
// Scoreboard bench for collision_arbiter: directed pixels push expected events,
// a negedge monitor pops and compares every accepted head.
module tb_collision_arbiter;
    localparam int unsigned NB    = 4;
    localparam int unsigned IW    = 2;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              resetN, startOfFrame, brikReq, batReq, bonusDrawReq;
    logic [NB-1:0]     ballReq;
    logic [11*NB-1:0]  ballOffsetX, ballOffsetY;
    logic [10:0]       batOffSetX;
    logic [2:0]        legnth;
    logic              overflow, bonusCollision;
    logic [7:0]        lastFrameHits;

    collision_arbiter_if #(.IDXW(IW)) evt_if ();

    collision_arbiter #(
        .NUM_BALLS(NB),
        .BALL_W(14),
        .EDGE(3),
        .DEPTH(DEPTH)
    ) dut (
        .clk           (clk),
        .resetN        (resetN),
        .startOfFrame  (startOfFrame),
        .ballReq       (ballReq),
        .ballOffsetX   (ballOffsetX),
        .ballOffsetY   (ballOffsetY),
        .brikReq       (brikReq),
        .batReq        (batReq),
        .bonusDrawReq  (bonusDrawReq),
        .batOffSetX    (batOffSetX),
        .legnth        (legnth),
        .evt           (evt_if),
        .overflow      (overflow),
        .bonusCollision(bonusCollision),
        .lastFrameHits (lastFrameHits)
    );

    typedef struct packed {
        logic [IW-1:0] ball;
        logic [3:0]    side;
        logic          brick;
        logic [2:0]    zone;
    } ev_t;

    ev_t sb[$];
    int  checks   = 0;
    int  failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin : monitor
        ev_t got, e;
        if (resetN && evt_if.evt_valid && evt_if.evt_ready) begin
            got = {evt_if.evt_ball, evt_if.evt_side, evt_if.evt_brick, evt_if.evt_batZone};
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event: got %0h expected none", got);
            end else begin
                e = sb.pop_front();
                chk("event", 32'(got), 32'(e));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic setb(input int i, input int x, input int y);
        ballOffsetX[i*11 +: 11] = 11'(x);
        ballOffsetY[i*11 +: 11] = 11'(y);
    endtask

    task automatic drive(input logic [NB-1:0] req, input logic brik, input logic bat,
                         input logic sof, input int bx, input int len);
        ballReq      = req;
        brikReq      = brik;
        batReq       = bat;
        startOfFrame = sof;
        batOffSetX   = 11'(bx);
        legnth       = 3'(len);
        step();
        ballReq      = '0;
        brikReq      = 1'b0;
        batReq       = 1'b0;
        startOfFrame = 1'b0;
        bonusDrawReq = 1'b0;
    endtask

    task automatic sof();
        drive('0, 1'b0, 1'b0, 1'b1, 0, 0);
    endtask

    task automatic expect_ev(input int b, input logic [3:0] s, input logic br, input int z);
        sb.push_back(ev_t'({IW'(b), s, br, 3'(z)}));
    endtask

    task automatic bonus_pixel();
        bonusDrawReq = 1'b1;
        drive('0, 1'b0, 1'b1, 1'b0, 0, 0);
    endtask

    initial begin
        resetN = 1'b0; startOfFrame = 1'b0; brikReq = 1'b0; batReq = 1'b0; bonusDrawReq = 1'b0;
        ballReq = '0; ballOffsetX = '0; ballOffsetY = '0; batOffSetX = '0; legnth = '0;
        evt_if.evt_ready = 1'b0;
        idle(2);
        resetN = 1'b1;
        step();

        // Reset state
        chk("rst_valid", 32'(evt_if.evt_valid), 0);
        chk("rst_ball", 32'(evt_if.evt_ball), 0);
        chk("rst_side", 32'(evt_if.evt_side), 0);
        chk("rst_brick", 32'(evt_if.evt_brick), 0);
        chk("rst_zone", 32'(evt_if.evt_batZone), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_bonus", 32'(bonusCollision), 0);
        chk("rst_last_hits", 32'(lastFrameHits), 0);

        // Bat hit on top side; two-cycle latency; zone 2 and zone 7
        evt_if.evt_ready = 1'b1;
        sof();
        setb(0, 5, 12);
        expect_ev(0, 4'b0010, 1'b0, 2);
        drive(4'b0001, 1'b0, 1'b1, 1'b0, 10, 2);
        chk("latency_c1_valid", 32'(evt_if.evt_valid), 0);
        step();
        chk("latency_c2_valid", 32'(evt_if.evt_valid), 1);
        setb(3, 0, 13);
        expect_ev(3, 4'b0010, 1'b0, 7);
        drive(4'b1000, 1'b0, 1'b1, 1'b0, 200, 7);
        idle(4);

        // One brick event per ball per frame; startOfFrame with a candidate re-arms
        sof();
        setb(0, 3, 6);
        expect_ev(0, 4'b1000, 1'b1, 0);
        drive(4'b0001, 1'b1, 1'b0, 1'b0, 0, 0);
        idle(2);
        drive(4'b0001, 1'b1, 1'b0, 1'b0, 0, 0);
        idle(3);
        expect_ev(0, 4'b1000, 1'b1, 0);
        drive(4'b0001, 1'b1, 1'b0, 1'b1, 0, 0);
        drive(4'b0001, 1'b1, 1'b0, 1'b0, 0, 0);
        idle(4);
        chk("sb_drained_a", 32'(sb.size()), 0);

        // Bonus pulse once per frame
        sof();
        bonus_pixel();
        chk("bonus_pulse", 32'(bonusCollision), 1);
        step();
        chk("bonus_clear", 32'(bonusCollision), 0);
        bonus_pixel();
        chk("bonus_once", 32'(bonusCollision), 0);
        sof();
        bonus_pixel();
        chk("bonus_rearm", 32'(bonusCollision), 1);

        // Priority between balls, then frame hit counter
        sof();
        setb(0, 10, 5);
        setb(1, 2, 1);
        setb(2, 0, 11);
        expect_ev(0, 4'b0100, 1'b1, 0);
        drive(4'b0011, 1'b1, 1'b0, 1'b0, 0, 0);
        expect_ev(1, 4'b0001, 1'b1, 0);
        drive(4'b0011, 1'b1, 1'b0, 1'b0, 0, 0);
        expect_ev(2, 4'b0010, 1'b0, 4);
        drive(4'b0100, 1'b0, 1'b1, 1'b0, 13, 0);
        idle(3);
        sof();
        chk("last_hits_3", 32'(lastFrameHits), 3);
        idle(2);
        sof();
        chk("last_hits_restart", 32'(lastFrameHits), 0);
        idle(2);

        // Fill FIFO with ready low, drop one, then push while popping when full
        evt_if.evt_ready = 1'b0;
        sof();
        setb(0, 3, 6);
        setb(1, 2, 1);
        setb(2, 6, 3);
        setb(3, 7, 10);
        expect_ev(0, 4'b1000, 1'b1, 0);
        expect_ev(1, 4'b0001, 1'b1, 0);
        expect_ev(2, 4'b1000, 1'b1, 0);
        expect_ev(3, 4'b0100, 1'b1, 0);
        repeat (4) drive(4'b1111, 1'b1, 1'b0, 1'b0, 0, 0);
        idle(3);
        drive(4'b0001, 1'b1, 1'b0, 1'b1, 0, 0);
        chk("last_hits_4", 32'(lastFrameHits), 4);
        idle(3);
        chk("ovf_set", 32'(overflow), 1);
        chk("full_valid", 32'(evt_if.evt_valid), 1);
        chk("full_head_ball", 32'(evt_if.evt_ball), 0);
        expect_ev(1, 4'b0001, 1'b0, 0);
        drive(4'b0010, 1'b0, 1'b1, 1'b0, 0, 0);
        evt_if.evt_ready = 1'b1;
        step();
        evt_if.evt_ready = 1'b0;
        step();
        chk("after_pushpop_head", 32'(evt_if.evt_ball), 1);
        evt_if.evt_ready = 1'b1;
        idle(8);
        chk("sb_drained_b", 32'(sb.size()), 0);
        chk("ovf_sticky", 32'(overflow), 1);

        // Reset with events queued
        evt_if.evt_ready = 1'b0;
        sof();
        chk("last_hits_1", 32'(lastFrameHits), 1);
        drive(4'b0011, 1'b1, 1'b0, 1'b0, 0, 0);
        drive(4'b0011, 1'b1, 1'b0, 1'b0, 0, 0);
        idle(3);
        chk("pre_rst_valid", 32'(evt_if.evt_valid), 1);
        resetN = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(evt_if.evt_valid), 0);
        chk("mid_rst_ovf", 32'(overflow), 0);
        chk("mid_rst_last", 32'(lastFrameHits), 0);
        step();
        resetN = 1'b1;
        idle(3);
        chk("post_rst_valid", 32'(evt_if.evt_valid), 0);
        evt_if.evt_ready = 1'b1;
        setb(2, 6, 3);
        expect_ev(2, 4'b1000, 1'b1, 0);
        drive(4'b0100, 1'b1, 1'b0, 1'b0, 0, 0);

        for (int n = 0; n < 100 && sb.size() != 0; n++) step();
        idle(2);
        chk("sb_final_empty", 32'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
